// File: rtl/io_bus_bridge.sv
// io_bus_bridge: decodes CPU bus accesses into RAM or I/O, buffers UART TX/RX bytes in two
// FIFOs, drives the program-stop flag and the io_buffer_full back-pressure signal.
// Optional feature: define IO_CYCLE_COUNTER_EN to build the 32-bit cycle counter served at
// 0x30004..0x30007; without it those addresses read as 0x00.
module io_bus_bridge #(
    parameter int unsigned TX_DEPTH_BIT = 4,
    parameter int unsigned RX_DEPTH_BIT = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [31:0] cpu_a,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_wr,
    output logic [7:0]  cpu_din,
    output logic        io_buffer_full,
    output logic        ram_en,
    input  logic [7:0]  ram_dout,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        program_stop
);

    localparam int unsigned TX_DEPTH   = 2 ** TX_DEPTH_BIT;
    localparam int unsigned RX_DEPTH   = 2 ** RX_DEPTH_BIT;
    localparam int unsigned TX_MARK_I  = TX_DEPTH - 2;
    localparam logic [TX_DEPTH_BIT:0]   TX_FULL_CNT = TX_DEPTH[TX_DEPTH_BIT:0];
    localparam logic [TX_DEPTH_BIT:0]   TX_MARK     = TX_MARK_I[TX_DEPTH_BIT:0];
    localparam logic [RX_DEPTH_BIT:0]   RX_FULL_CNT = RX_DEPTH[RX_DEPTH_BIT:0];
    localparam logic [TX_DEPTH_BIT-1:0] TX_PTR_ONE  = 1;
    localparam logic [RX_DEPTH_BIT-1:0] RX_PTR_ONE  = 1;

    localparam logic [17:0] ADDR_UART = 18'h30000;
    localparam logic [17:0] ADDR_CNT  = 18'h30004;

    // Address bits above 17 are not decoded.
    logic unused_addr_hi;
    assign unused_addr_hi = ^cpu_a[31:18];

    logic                    io_sel;
    logic                    wr_uart;
    logic                    wr_stop;
    logic                    rd_uart;
    logic                    tx_push;
    logic                    tx_pop;
    logic [7:0]              tx_wdata;
    logic                    rx_push;
    logic                    rx_pop;
    logic [7:0]              io_rdata_d;

    logic [TX_DEPTH_BIT-1:0] tx_head_q;
    logic [TX_DEPTH_BIT-1:0] tx_tail_q;
    logic [TX_DEPTH_BIT:0]   tx_count_q;
    logic [7:0]              tx_mem [TX_DEPTH];

    logic [RX_DEPTH_BIT-1:0] rx_head_q;
    logic [RX_DEPTH_BIT-1:0] rx_tail_q;
    logic [RX_DEPTH_BIT:0]   rx_count_q;
    logic [7:0]              rx_mem [RX_DEPTH];

    logic                    io_sel_q;
    logic [7:0]              io_rdata_q;
    logic                    program_stop_q;

`ifdef IO_CYCLE_COUNTER_EN
    logic                    rd_cnt;
    logic [31:0]             cycle_cnt_q;
    logic [23:0]             cnt_snap_q;
`endif

    // Bus decode and FIFO handshake qualifiers.
    always_comb begin
        io_sel   = (cpu_a[17:16] == 2'b11);
        wr_uart  = rdy_in && io_sel && cpu_wr && (cpu_a[17:0] == ADDR_UART) &&
                   !program_stop_q && (cpu_dout != 8'h00);
        wr_stop  = rdy_in && io_sel && cpu_wr && (cpu_a[17:0] == ADDR_CNT) && !program_stop_q;
        rd_uart  = rdy_in && io_sel && !cpu_wr && (cpu_a[17:0] == ADDR_UART);
        // A push into a full TX FIFO is dropped even if a pop happens in the same cycle.
        tx_push  = (wr_uart || wr_stop) && (tx_count_q != TX_FULL_CNT);
        tx_wdata = wr_stop ? 8'h00 : cpu_dout;
        tx_pop   = tx_valid && tx_ready;
        rx_push  = rx_valid && rx_ready;
        rx_pop   = rd_uart && (rx_count_q != '0);
    end

    assign ram_en         = !io_sel;
    assign tx_valid       = rst_in && (tx_count_q != '0);
    assign tx_data        = tx_mem[tx_head_q];
    assign rx_ready       = rst_in && (rx_count_q != RX_FULL_CNT);
    assign io_buffer_full = (tx_count_q >= TX_MARK);
    assign program_stop   = program_stop_q;
    assign cpu_din        = io_sel_q ? io_rdata_q : ram_dout;

    // TX FIFO pointers and occupancy.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            tx_head_q  <= '0;
            tx_tail_q  <= '0;
            tx_count_q <= '0;
        end else begin
            if (tx_push) tx_tail_q <= tx_tail_q + TX_PTR_ONE;
            if (tx_pop)  tx_head_q <= tx_head_q + TX_PTR_ONE;
            tx_count_q <= tx_count_q + {{TX_DEPTH_BIT{1'b0}}, tx_push}
                                     - {{TX_DEPTH_BIT{1'b0}}, tx_pop};
        end
    end

    // TX FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk_in) begin
        if (tx_push) tx_mem[tx_tail_q] <= tx_wdata;
    end

    // RX FIFO pointers and occupancy.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            rx_head_q  <= '0;
            rx_tail_q  <= '0;
            rx_count_q <= '0;
        end else begin
            if (rx_push) rx_tail_q <= rx_tail_q + RX_PTR_ONE;
            if (rx_pop)  rx_head_q <= rx_head_q + RX_PTR_ONE;
            rx_count_q <= rx_count_q + {{RX_DEPTH_BIT{1'b0}}, rx_push}
                                     - {{RX_DEPTH_BIT{1'b0}}, rx_pop};
        end
    end

    // RX FIFO storage.
    always_ff @(posedge clk_in) begin
        if (rx_push) rx_mem[rx_tail_q] <= rx_data;
    end

    // I/O read data selection for the current access.
    always_comb begin
        io_rdata_d = 8'h00;
`ifdef IO_CYCLE_COUNTER_EN
        rd_cnt = rdy_in && io_sel && !cpu_wr && (cpu_a[17:2] == ADDR_CNT[17:2]);
`endif
        if (rx_pop) begin
            io_rdata_d = rx_mem[rx_head_q];
        end
`ifdef IO_CYCLE_COUNTER_EN
        else if (rd_cnt) begin
            unique case (cpu_a[1:0])
                2'd0:    io_rdata_d = cycle_cnt_q[7:0];
                2'd1:    io_rdata_d = cnt_snap_q[7:0];
                2'd2:    io_rdata_d = cnt_snap_q[15:8];
                default: io_rdata_d = cnt_snap_q[23:16];
            endcase
        end
`endif
    end

    // Read-mux state and sticky stop flag; frozen while rdy_in is low.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            io_sel_q       <= 1'b1;
            io_rdata_q     <= 8'h00;
            program_stop_q <= 1'b0;
        end else if (rdy_in) begin
            io_sel_q   <= io_sel;
            io_rdata_q <= io_rdata_d;
            if (wr_stop) program_stop_q <= 1'b1;
        end
    end

`ifdef IO_CYCLE_COUNTER_EN
    // Free-running cycle counter; reading the low byte snapshots the upper three bytes so a
    // multi-byte read sees a coherent value.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            cycle_cnt_q <= '0;
            cnt_snap_q  <= '0;
        end else if (rdy_in) begin
            cycle_cnt_q <= cycle_cnt_q + 32'd1;
            if (rd_cnt && (cpu_a[1:0] == 2'd0)) cnt_snap_q <= cycle_cnt_q[31:8];
        end
    end
`endif

endmodule
